// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, control codes, controller state type and the
// logical-to-physical cell address helper for the text console.
package disp_pkg;

    localparam int unsigned CHARS_HORZ = 80;
    localparam int unsigned CHARS_VERT = 30;
    localparam int unsigned ASCII_SIZE = 8;
    localparam int unsigned ROW_W      = 5;
    localparam int unsigned COL_W      = 7;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned SUM_W      = ROW_W + 1;
    localparam int unsigned NUM_CELLS  = CHARS_HORZ * CHARS_VERT;

    localparam logic [ASCII_SIZE-1:0] BLANK_CHAR = 8'h20;
    localparam logic [ASCII_SIZE-1:0] CC_BS      = 8'h08;
    localparam logic [ASCII_SIZE-1:0] CC_LF      = 8'h0A;
    localparam logic [ASCII_SIZE-1:0] CC_FF      = 8'h0C;
    localparam logic [ASCII_SIZE-1:0] CC_CR      = 8'h0D;
    localparam logic [ASCII_SIZE-1:0] PRINT_LO   = 8'h20;
    localparam logic [ASCII_SIZE-1:0] PRINT_HI   = 8'h7E;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(CHARS_VERT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(CHARS_HORZ - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [2:0] {
        INIT_CLEAR,
        IDLE,
        EXEC,
        CLEAR_LINE,
        CLEAR_ALL
    } console_state_t;

    // Logical row is rotated by the scroll base; wrap without a modulo.
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [ROW_W-1:0] lrow,
        input logic [ROW_W-1:0] base,
        input logic [COL_W-1:0] col
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, lrow} + {1'b0, base};
        if (sum >= SUM_W'(CHARS_VERT)) begin
            sum = sum - SUM_W'(CHARS_VERT);
        end
        return ADDR_W'(sum[ROW_W-1:0]) * ADDR_W'(CHARS_HORZ) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/char_ram.sv
// char_ram: single-port synchronous 2400x8 character store, registered read.
// Ports: clk, rst_n (async, clears the read register only), en_i (access),
// we_i (1=write, 0=read), addr_i, wdata_i, rdata_o (valid the cycle after a read).
module char_ram
    import disp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [ASCII_SIZE-1:0] wdata_i,
    output logic [ASCII_SIZE-1:0] rdata_o
);

    logic [ASCII_SIZE-1:0] mem_q [NUM_CELLS];
    logic [ASCII_SIZE-1:0] rdata_q;
    logic                  in_range;

    assign in_range = (addr_i < ADDR_W'(NUM_CELLS));

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i && in_range) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/console_ctrl.sv
// console_ctrl: text console controller. Converts a CPU character stream into
// character-RAM writes with cursor tracking, control codes, hardware scroll
// (row base rotation) and clears, and shares the RAM port with draw reads,
// which always take priority.
// Ports: clk_25M, rst_n; cpuValid/cpuChar/cpuReady (CPU handshake);
// rdEn/rdRow/rdCol -> rdChar/rdValid (draw read, 1-cycle latency);
// cursorRow/cursorCol (logical cursor); busy (not IDLE).
module console_ctrl
    import disp_pkg::*;
(
    input  logic                  clk_25M,
    input  logic                  rst_n,
    input  logic                  cpuValid,
    input  logic [ASCII_SIZE-1:0] cpuChar,
    output logic                  cpuReady,
    input  logic                  rdEn,
    input  logic [ROW_W-1:0]      rdRow,
    input  logic [COL_W-1:0]      rdCol,
    output logic [ASCII_SIZE-1:0] rdChar,
    output logic                  rdValid,
    output logic [ROW_W-1:0]      cursorRow,
    output logic [COL_W-1:0]      cursorCol,
    output logic                  busy
);

    console_state_t        state_q, state_d;
    logic [ADDR_W-1:0]     clr_q, clr_d;
    logic [ASCII_SIZE-1:0] char_q, char_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      base_q, base_d;
    logic                  rd_valid_q;

    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ASCII_SIZE-1:0] wr_data;
    logic                  slot;
    logic                  newline;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;

    // A write may use the port only when the draw side is not reading.
    assign slot    = !rdEn;
    assign rd_addr = cell_addr(rdRow, base_q, rdCol);

    // State and datapath registers.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_CLEAR;
            clr_q      <= '0;
            char_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            char_q     <= char_d;
            row_q      <= row_d;
            col_q      <= col_d;
            base_q     <= base_d;
            rd_valid_q <= rdEn;
        end
    end

    // Next-state, cursor/scroll update and write request.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        char_d  = char_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = BLANK_CHAR;
        newline = 1'b0;

        unique case (state_q)
            INIT_CLEAR, CLEAR_ALL: begin
                wr_req  = 1'b1;
                wr_addr = clr_q;
                if (slot) begin
                    if (clr_q == LAST_CELL) begin
                        clr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        clr_d = clr_q + ADDR_W'(1);
                    end
                end
            end

            // Clears the row that just became logical row 29 after a scroll.
            CLEAR_LINE: begin
                wr_req  = 1'b1;
                wr_addr = cell_addr(LAST_ROW, base_q, clr_q[COL_W-1:0]);
                if (slot) begin
                    if (clr_q[COL_W-1:0] == LAST_COL) begin
                        clr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        clr_d = clr_q + ADDR_W'(1);
                    end
                end
            end

            IDLE: begin
                if (cpuValid) begin
                    char_d  = cpuChar;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = IDLE;
                if (char_q >= PRINT_LO && char_q <= PRINT_HI) begin
                    wr_req  = 1'b1;
                    wr_addr = cell_addr(row_q, base_q, col_q);
                    wr_data = char_q;
                    if (slot) begin
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        state_d = EXEC;
                    end
                end else if (char_q == CC_LF) begin
                    col_d   = '0;
                    newline = 1'b1;
                end else if (char_q == CC_CR) begin
                    col_d = '0;
                end else if (char_q == CC_BS) begin
                    if (col_q != '0) begin
                        wr_req  = 1'b1;
                        wr_addr = cell_addr(row_q, base_q, col_q - COL_W'(1));
                        if (slot) begin
                            col_d = col_q - COL_W'(1);
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end else if (char_q == CC_FF) begin
                    base_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    clr_d   = '0;
                    state_d = CLEAR_ALL;
                end

                // Bottom-row newline scrolls by rotating the row base.
                if (newline) begin
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        base_d  = (base_q == LAST_ROW) ? '0 : base_q + ROW_W'(1);
                        clr_d   = '0;
                        state_d = CLEAR_LINE;
                    end
                end
            end

            default: state_d = INIT_CLEAR;
        endcase
    end

    // Port arbitration: draw read wins over any pending write.
    assign ram_en   = rdEn || wr_req;
    assign ram_we   = slot && wr_req;
    assign ram_addr = rdEn ? rd_addr : wr_addr;

    char_ram u_char_ram (
        .clk     (clk_25M),
        .rst_n   (rst_n),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (rdChar)
    );

    assign cpuReady  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rdValid   = rd_valid_q;
    assign cursorRow = row_q;
    assign cursorCol = col_q;

endmodule

// File: tb/tb_console_ctrl.sv
// tb_console_ctrl: self-checking bench for console_ctrl. Keeps a logical
// 30x80 screen model (scrolling shifts rows) and checks read data, read
// latency, handshake and cursor against it every cycle, plus literal pins.
module tb_console_ctrl;

    localparam int BUDGET = 4000;

    logic       clk;
    logic       rst_n;
    logic       cpuValid;
    logic [7:0] cpuChar;
    logic       cpuReady;
    logic       rdEn;
    logic [4:0] rdRow;
    logic [6:0] rdCol;
    logic [7:0] rdChar;
    logic       rdValid;
    logic [4:0] cursorRow;
    logic [6:0] cursorCol;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] scr [30][80];
    int         m_row;
    int         m_col;
    bit         model_valid = 0;

    bit         prev_rd = 0;
    logic [7:0] exp_rd  = 8'h00;

    console_ctrl dut (
        .clk_25M   (clk),
        .rst_n     (rst_n),
        .cpuValid  (cpuValid),
        .cpuChar   (cpuChar),
        .cpuReady  (cpuReady),
        .rdEn      (rdEn),
        .rdRow     (rdRow),
        .rdCol     (rdCol),
        .rdChar    (rdChar),
        .rdValid   (rdValid),
        .cursorRow (cursorRow),
        .cursorCol (cursorCol),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_blank();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                scr[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    // Screen behaviour expressed on logical rows: a bottom newline shifts
    // every row up by one and blanks the bottom row.
    task automatic model_apply(input logic [7:0] ch);
        bit nl;
        nl = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[m_row][m_col] = ch;
            if (m_col == 79) begin
                m_col = 0;
                nl    = 1;
            end else begin
                m_col++;
            end
        end else if (ch == 8'h0A) begin
            m_col = 0;
            nl    = 1;
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                scr[m_row][m_col] = 8'h20;
            end
        end else if (ch == 8'h0C) begin
            model_blank();
        end
        if (nl) begin
            if (m_row < 29) begin
                m_row++;
            end else begin
                for (int r = 0; r < 29; r++)
                    for (int c = 0; c < 80; c++)
                        scr[r][c] = scr[r+1][c];
                for (int c = 0; c < 80; c++)
                    scr[29][c] = 8'h20;
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 0;
        end else begin
            chk("rdValid_latency", int'(rdValid), int'(prev_rd));
            if (prev_rd)
                chk("rdChar_vs_model", int'(rdChar), int'(exp_rd));
            chk("cpuReady_vs_busy", int'(cpuReady), int'(!busy));
            if (model_valid && !busy) begin
                chk("cursorRow_vs_model", int'(cursorRow), m_row);
                chk("cursorCol_vs_model", int'(cursorCol), m_col);
            end
            prev_rd = rdEn;
            if (rdEn && rdRow < 30 && rdCol < 80)
                exp_rd = scr[rdRow][rdCol];
        end
    end

    // Offer one character; optionally wait until the controller is idle
    // again and fold the character into the model. Returns busy cycles.
    task automatic send_char(input logic [7:0] ch, input bit wait_done, output int busy_cnt);
        int n;
        busy_cnt    = 0;
        model_valid = 0;
        @(posedge clk) #1;
        cpuValid = 1'b1;
        cpuChar  = ch;
        n = 0;
        @(negedge clk);
        while (!cpuReady && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            chk("handshake_timeout", 1, 0);
            cpuValid = 1'b0;
            return;
        end
        @(posedge clk) #1;
        cpuValid = 1'b0;
        if (!wait_done) return;
        @(negedge clk);
        while (busy && busy_cnt < BUDGET) begin
            busy_cnt++;
            @(negedge clk);
        end
        if (busy_cnt >= BUDGET) chk("idle_timeout", 1, 0);
        model_apply(ch);
        model_valid = 1;
    endtask

    task automatic send(input logic [7:0] ch);
        int dummy;
        send_char(ch, 1, dummy);
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        @(posedge clk) #1;
        rdEn  = 1'b1;
        rdRow = 5'(r);
        rdCol = 7'(c);
        @(posedge clk) #1;
        rdEn = 1'b0;
        v = rdChar;
    endtask

    // Back-to-back reads of logical rows r0..r1; checked by the compare process.
    task automatic read_rows(input int r0, input int r1);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < 80; c++) begin
                @(posedge clk) #1;
                rdEn  = 1'b1;
                rdRow = 5'(r);
                rdCol = 7'(c);
            end
        @(posedge clk) #1;
        rdEn = 1'b0;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < BUDGET) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_cpuReady", int'(cpuReady), 0);
        chk("rst_rdValid", int'(rdValid), 0);
        chk("rst_rdChar", int'(rdChar), 0);
        chk("rst_cursorRow", int'(cursorRow), 0);
        chk("rst_cursorCol", int'(cursorCol), 0);
        chk("rst_busy", int'(busy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cnt;
        int         t_drop;
        int         t_idle;
        logic [7:0] v;

        rst_n    = 1'b0;
        cpuValid = 1'b0;
        cpuChar  = 8'h00;
        rdEn     = 1'b0;
        rdRow    = '0;
        rdCol    = '0;
        t_drop   = 0;
        t_idle   = 0;

        // Reset and initial clear
        repeat (3) @(negedge clk);
        check_reset_values();
        @(posedge clk) #1;
        rst_n = 1'b1;
        wait_init(cnt);
        chk("init_busy_cycles", cnt, 2400);
        chk("init_cpuReady", int'(cpuReady), 1);
        model_blank();
        model_valid = 1;
        read_rows(0, 29);
        read_cell(17, 42, v);
        chk("init_cell_blank", int'(v), 8'h20);

        // Single character
        send(8'h41);
        read_cell(0, 0, v);
        chk("A_cell", int'(v), 8'h41);
        chk("A_cursorCol", int'(cursorCol), 1);

        // 80 characters from column 0 wrap to the next row
        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'(8'h21 + i));
        chk("wrap_cursorRow", int'(cursorRow), 1);
        chk("wrap_cursorCol", int'(cursorCol), 0);
        read_cell(0, 0, v);
        chk("row0_first", int'(v), 8'h21);
        read_cell(0, 79, v);
        chk("row0_last", int'(v), 8'h70);
        read_rows(0, 1);

        // Scroll at the bottom row; busy = 1 EXEC cycle + 80 line-clear writes
        send(8'h5A);
        for (int i = 0; i < 28; i++) send(8'h0A);
        chk("pre_scroll_row", int'(cursorRow), 29);
        send_char(8'h0A, 1, cnt);
        chk("scroll_busy_cycles", cnt, 81);
        chk("scroll_cursorRow", int'(cursorRow), 29);
        chk("scroll_cursorCol", int'(cursorCol), 0);
        read_cell(0, 0, v);
        chk("scroll_row0_is_old_row1", int'(v), 8'h5A);
        read_cell(29, 0, v);
        chk("scroll_row29_blank", int'(v), 8'h20);
        read_rows(0, 29);

        // Long draw burst stalls a pending write without loss
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    @(posedge clk) #1;
                    rdEn  = 1'b1;
                    rdRow = 5'd29;
                    rdCol = 7'(i % 80);
                end
                chk("stall_busy", int'(busy), 1);
                chk("stall_no_cursor_move", int'(cursorCol), 0);
                @(posedge clk) #1;
                rdEn   = 1'b0;
                t_drop = cyc;
            end
            begin
                send(8'h42);
                t_idle = cyc;
            end
        join
        chk("stall_release_within_2", int'((t_idle - t_drop) >= 1 && (t_idle - t_drop) <= 2), 1);
        read_cell(29, 0, v);
        chk("stall_cell", int'(v), 8'h42);
        chk("stall_cursorCol", int'(cursorCol), 1);

        // Backspace at column 0 and mid-row
        send(8'h0D);
        send(8'h08);
        chk("bs_col0_cursor", int'(cursorCol), 0);
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
        send(8'h08);
        chk("bs_cursorCol", int'(cursorCol), 4);
        read_cell(29, 4, v);
        chk("bs_cell_blank", int'(v), 8'h20);
        read_cell(29, 3, v);
        chk("bs_prev_cell", int'(v), 8'h64);

        // Form feed: home cursor and clear everything (1 EXEC + 2400 writes)
        send_char(8'h0C, 1, cnt);
        chk("ff_busy_cycles", cnt, 2401);
        chk("ff_cursorRow", int'(cursorRow), 0);
        chk("ff_cursorCol", int'(cursorCol), 0);
        read_rows(0, 29);

        // Unknown code is discarded in one EXEC cycle
        send(8'h51);
        send_char(8'h07, 1, cnt);
        chk("bel_busy_cycles", cnt, 1);
        chk("bel_cursorCol", int'(cursorCol), 1);
        read_cell(0, 1, v);
        chk("bel_no_write", int'(v), 8'h20);

        // Reset in the middle of a full clear restarts the init sweep
        read_cell(0, 0, v);
        send_char(8'h0C, 0, cnt);
        model_valid = 0;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init(cnt);
        chk("reinit_busy_cycles", cnt, 2400);
        model_blank();
        model_valid = 1;
        read_rows(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
